// File: rtl/bsg_nonsynth_manycore_pod_reset_client_if.sv
// Tag lane carried from the manycore tag master to a per-pod reset client.
// The master drives op/param/en, and the client samples them on its own clock.
interface bsg_nonsynth_manycore_pod_reset_client_if;
    logic op;
    logic param;
    logic en;

    modport master (output op, output param, output en);
    modport slave  (input op, input param, input en);
endinterface

// File: rtl/bsg_nonsynth_manycore_pod_reset_client.sv
// Per-pod tag client: deserializes tag packets into a committed payload and turns
// payload bit 0 into a held pod reset, which is released only after a minimum delay.
module bsg_nonsynth_manycore_pod_reset_client #(
    parameter int unsigned width_p             = 1,
    parameter int unsigned reset_hold_cycles_p = 16
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    bsg_nonsynth_manycore_pod_reset_client_if.slave    tag_i,
    output logic [width_p-1:0]                         data_o,
    output logic                                       new_o,
    output logic                                       pod_reset_o,
    output logic                                       error_o
);

    localparam int unsigned cnt_width_lp  = $clog2(width_p + 1);
    localparam int unsigned hold_width_lp =
        (reset_hold_cycles_p > 1) ? $clog2(reset_hold_cycles_p) : 1;
    localparam logic [cnt_width_lp-1:0]  cnt_max_lp   = cnt_width_lp'(width_p);
    localparam logic [hold_width_lp-1:0] hold_init_lp = hold_width_lp'(reset_hold_cycles_p - 1);

    typedef enum logic [1:0] {StAssert, StHold, StReleased} state_e;

    logic [width_p-1:0]       sr_r, sr_n, sr_shift;
    logic [width_p-1:0]       data_r, data_n;
    logic [cnt_width_lp-1:0]  cnt_r, cnt_n;
    logic                     new_r, new_n;
    logic                     error_r, error_n;
    state_e                   state_r, state_n;
    logic [hold_width_lp-1:0] hold_cnt_r, hold_cnt_n;

    // LSB is sent first, so new bits enter at the top and move down.
    if (width_p == 1) begin : g_shift_1
        assign sr_shift = tag_i.param;
    end else begin : g_shift_n
        assign sr_shift = {tag_i.param, sr_r[width_p-1:1]};
    end

    always_comb begin
        sr_n    = sr_r;
        cnt_n   = cnt_r;
        data_n  = data_r;
        new_n   = 1'b0;
        error_n = error_r;
        if (tag_i.en) begin
            cnt_n = '0;
            if (cnt_r == cnt_max_lp) begin
                data_n = sr_r;
                new_n  = (sr_r != data_r);
            end else begin
                error_n = 1'b1;
            end
        end else if (!tag_i.op && tag_i.param) begin
            sr_n  = '0;
            cnt_n = '0;
        end else if (tag_i.op) begin
            sr_n = sr_shift;
            if (cnt_r != cnt_max_lp) cnt_n = cnt_r + cnt_width_lp'(1);
        end
    end

    // The FSM acts on the committed payload, so tag_i reaches pod_reset_o only through registers.
    always_comb begin
        state_n    = state_r;
        hold_cnt_n = hold_cnt_r;
        unique case (state_r)
            StAssert: begin
                if (!data_r[0]) begin
                    state_n    = StHold;
                    hold_cnt_n = hold_init_lp;
                end
            end
            StHold: begin
                if (data_r[0])               state_n = StAssert;
                else if (hold_cnt_r == '0)   state_n = StReleased;
                else                         hold_cnt_n = hold_cnt_r - hold_width_lp'(1);
            end
            StReleased: begin
                if (data_r[0]) state_n = StAssert;
            end
            default: state_n = StAssert;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sr_r       <= '0;
            cnt_r      <= '0;
            data_r     <= width_p'(1);
            new_r      <= 1'b0;
            error_r    <= 1'b0;
            state_r    <= StAssert;
            hold_cnt_r <= '0;
        end else begin
            sr_r       <= sr_n;
            cnt_r      <= cnt_n;
            data_r     <= data_n;
            new_r      <= new_n;
            error_r    <= error_n;
            state_r    <= state_n;
            hold_cnt_r <= hold_cnt_n;
        end
    end

    assign data_o      = data_r;
    assign new_o       = new_r;
    assign error_o     = error_r;
    assign pod_reset_o = (state_r != StReleased);

endmodule

// File: tb/tb_bsg_nonsynth_manycore_pod_reset_client.sv
// Directed bench: a 1-bit client with the default hold and a 4-bit client, sharing clock and reset.
module tb_bsg_nonsynth_manycore_pod_reset_client;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bsg_nonsynth_manycore_pod_reset_client_if tag1 ();
    bsg_nonsynth_manycore_pod_reset_client_if tag4 ();

    logic       data1, new1, rst1, err1;
    logic [3:0] data4;
    logic       new4, rst4, err4;

    bsg_nonsynth_manycore_pod_reset_client #(.width_p(1), .reset_hold_cycles_p(16)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .tag_i(tag1),
        .data_o(data1), .new_o(new1), .pod_reset_o(rst1), .error_o(err1)
    );

    bsg_nonsynth_manycore_pod_reset_client #(.width_p(4), .reset_hold_cycles_p(16)) u_dut4 (
        .clk_i(clk), .reset_i(reset), .tag_i(tag4),
        .data_o(data4), .new_o(new4), .pod_reset_o(rst4), .error_o(err4)
    );

    // Drive one cycle on a lane, then return to idle; outputs are sampled 1ns after the edge.
    task automatic step1(input logic op, input logic param, input logic en);
        tag1.op = op; tag1.param = param; tag1.en = en;
        @(posedge clk); #1;
        tag1.op = 1'b0; tag1.param = 1'b0; tag1.en = 1'b0;
    endtask

    task automatic step4(input logic op, input logic param, input logic en);
        tag4.op = op; tag4.param = param; tag4.en = en;
        @(posedge clk); #1;
        tag4.op = 1'b0; tag4.param = 1'b0; tag4.en = 1'b0;
    endtask

    task automatic test_reset;
        tag1.op = 1'b0; tag1.param = 1'b0; tag1.en = 1'b0;
        tag4.op = 1'b0; tag4.param = 1'b0; tag4.en = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rst1 !== 1'b1) begin errors++; $display("FAIL reset_pod_reset got %b want 1", rst1); end
        checks++; if (data1 !== 1'b1) begin errors++; $display("FAIL reset_data1 got %b want 1", data1); end
        checks++; if (new1 !== 1'b0) begin errors++; $display("FAIL reset_new got %b want 0", new1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", err1); end
        checks++; if (data4 !== 4'b0001) begin errors++; $display("FAIL reset_data4 got %b want 0001", data4); end
        reset = 1'b0;
        step1(0, 0, 0);
        checks++; if (rst1 !== 1'b1) begin errors++; $display("FAIL reset_stays_asserted got %b want 1", rst1); end
    endtask

    task automatic test_basic_release;
        bit ok = 1'b1;
        step1(1, 0, 0);
        step1(0, 0, 1);
        checks++; if (data1 !== 1'b0) begin errors++; $display("FAIL release_data got %b want 0", data1); end
        checks++; if (new1 !== 1'b1) begin errors++; $display("FAIL release_new got %b want 1", new1); end
        for (int k = 1; k <= 16; k++) begin
            step1(0, 0, 0);
            if (k == 1) begin
                checks++;
                if (new1 !== 1'b0) begin errors++; $display("FAIL release_new_pulse got %b want 0", new1); end
            end
            if (rst1 !== 1'b1) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL release_hold early fall got 0 want 1"); end
        step1(0, 0, 0);
        checks++; if (rst1 !== 1'b0) begin errors++; $display("FAIL release_fall got %b want 0", rst1); end
    endtask

    task automatic test_reassert;
        step1(1, 1, 0);
        step1(0, 0, 1);
        checks++; if (data1 !== 1'b1) begin errors++; $display("FAIL reassert_data got %b want 1", data1); end
        checks++; if (new1 !== 1'b1) begin errors++; $display("FAIL reassert_new got %b want 1", new1); end
        checks++; if (rst1 !== 1'b0) begin errors++; $display("FAIL reassert_latency got %b want 0", rst1); end
        step1(0, 0, 0);
        checks++; if (rst1 !== 1'b1) begin errors++; $display("FAIL reassert_rise got %b want 1", rst1); end
        checks++; if (new1 !== 1'b0) begin errors++; $display("FAIL reassert_new_drop got %b want 0", new1); end
    endtask

    task automatic test_short_packet;
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL short_err_pre got %b want 0", err4); end
        step4(1, 1, 0); step4(1, 1, 0); step4(1, 1, 0);
        step4(0, 0, 1);
        checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", err4); end
        checks++; if (data4 !== 4'b0001) begin errors++; $display("FAIL short_data got %b want 0001", data4); end
        checks++; if (new4 !== 1'b0) begin errors++; $display("FAIL short_new got %b want 0", new4); end
        step4(1, 1, 0); step4(1, 0, 0); step4(1, 1, 0); step4(1, 0, 0);
        step4(0, 0, 1);
        checks++; if (data4 !== 4'b0101) begin errors++; $display("FAIL full_data got %b want 0101", data4); end
        checks++; if (new4 !== 1'b1) begin errors++; $display("FAIL full_new got %b want 1", new4); end
        checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err4); end
    endtask

    task automatic test_identical_and_clear;
        step4(1, 1, 0); step4(1, 0, 0); step4(1, 1, 0); step4(1, 0, 0);
        step4(0, 0, 1);
        checks++; if (new4 !== 1'b0) begin errors++; $display("FAIL identical_new got %b want 0", new4); end
        checks++; if (data4 !== 4'b0101) begin errors++; $display("FAIL identical_data got %b want 0101", data4); end
        step4(1, 1, 0); step4(1, 1, 0);
        step4(0, 1, 0);
        step4(1, 0, 0); step4(1, 1, 0); step4(1, 1, 0); step4(1, 0, 0);
        step4(0, 0, 1);
        checks++; if (data4 !== 4'b0110) begin errors++; $display("FAIL clear_data got %b want 0110", data4); end
        checks++; if (new4 !== 1'b1) begin errors++; $display("FAIL clear_new got %b want 1", new4); end
        // Clear resets the bit count, so three shifts afterwards are a short packet.
        step4(1, 1, 0); step4(1, 1, 0);
        step4(0, 1, 0);
        step4(1, 1, 0); step4(1, 1, 0); step4(1, 1, 0);
        step4(0, 0, 1);
        checks++; if (data4 !== 4'b0110) begin errors++; $display("FAIL clear_count got %b want 0110", data4); end
        checks++; if (new4 !== 1'b0) begin errors++; $display("FAIL clear_count_new got %b want 0", new4); end
    endtask

    task automatic test_abort_hold;
        bit ok = 1'b1;
        step1(1, 0, 0);
        step1(0, 0, 1);
        step1(0, 0, 0); step1(0, 0, 0); step1(0, 0, 0);
        step1(1, 1, 0);
        step1(0, 0, 1);
        checks++; if (new1 !== 1'b1) begin errors++; $display("FAIL abort_new got %b want 1", new1); end
        for (int k = 0; k < 25; k++) begin
            if (rst1 !== 1'b1) ok = 1'b0;
            step1(0, 0, 0);
        end
        checks++; if (!ok) begin errors++; $display("FAIL abort_no_fall got 0 want 1"); end
        ok = 1'b1;
        step1(1, 0, 0);
        step1(0, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            step1(0, 0, 0);
            if (rst1 !== 1'b1) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL abort_reload early fall got 0 want 1"); end
        step1(0, 0, 0);
        checks++; if (rst1 !== 1'b0) begin errors++; $display("FAIL abort_fall got %b want 0", rst1); end
    endtask

    task automatic test_async_reset;
        bit ok = 1'b1;
        step1(1, 1, 0);
        step1(0, 0, 1);
        step1(1, 0, 0);
        step1(0, 0, 1);
        step1(0, 0, 0);
        step1(1, 1, 0);
        step1(1, 1, 0);
        checks++; if (data1 !== 1'b0) begin errors++; $display("FAIL async_pre_data got %b want 0", data1); end
        #2 reset = 1'b1;
        #1;
        checks++; if (rst1 !== 1'b1) begin errors++; $display("FAIL async_pod_reset got %b want 1", rst1); end
        checks++; if (data1 !== 1'b1) begin errors++; $display("FAIL async_data got %b want 1", data1); end
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL async_error got %b want 0", err4); end
        checks++; if (data4 !== 4'b0001) begin errors++; $display("FAIL async_data4 got %b want 0001", data4); end
        reset = 1'b0;
        #1;
        step1(0, 0, 0);
        checks++; if (new1 !== 1'b0) begin errors++; $display("FAIL async_new got %b want 0", new1); end
        step1(1, 0, 0);
        step1(0, 0, 1);
        checks++; if (data1 !== 1'b0) begin errors++; $display("FAIL fresh_data got %b want 0", data1); end
        checks++; if (new1 !== 1'b1) begin errors++; $display("FAIL fresh_new got %b want 1", new1); end
        for (int k = 1; k <= 16; k++) begin
            step1(0, 0, 0);
            if (rst1 !== 1'b1) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL fresh_hold early fall got 0 want 1"); end
        step1(0, 0, 0);
        checks++; if (rst1 !== 1'b0) begin errors++; $display("FAIL fresh_fall got %b want 0", rst1); end
    endtask

    initial begin
        test_reset();
        test_basic_release();
        test_reassert();
        test_short_packet();
        test_identical_and_clear();
        test_abort_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_nonsynth_manycore_pod_reset_client.md
# bsg_nonsynth_manycore_pod_reset_client

Per-pod tag client sitting directly downstream of the manycore tag master. Consumes one `bsg_tag_s` lane and deserializes tag packets into a committed payload register. Converts payload bit 0 into a held, glitch-free pod reset, stretched by a minimum release delay. Testbenches instantiate one per pod, connecting `pod_tags_o[y][x]` of the master to `tag_i`.

## Interface
- `width_p`, default 1: payload width in bits; bit 0 is the pod reset request. Must be ≥ 1.
- `reset_hold_cycles_p`, default 16: minimum cycles `pod_reset_o` stays high after a release is committed. Must be ≥ 1.
- `clk_i` input 1: single clock; all state updates on its rising edge.
- `reset_i` input 1: asynchronous, active-high reset.
- `tag_i` input `bsg_tag_s`: tag lane; fields `op`, `param` and `en` are sampled on `clk_i`; `clk` field ignored.
- `data_o` output `width_p`: last committed payload.
- `new_o` output 1: one-cycle pulse when a commit changes `data_o`.
- `pod_reset_o` output 1: reset to the pod.
- `error_o` output 1: sticky; set on a short-packet commit.

## Operation
- Shift register `sr_r[width_p-1:0]` and bit counter `cnt_r` (0..`width_p`, saturating).
- Per cycle, priority order:
  - **Commit.** When `en=1`, `op` and `param` are ignored.
    - If `cnt_r==width_p`: `data_r<=sr_r`; `new_o<=(sr_r!=data_r)`.
    - Otherwise: no commit, `error_o<=1`.
    - In both cases `cnt_r<=0`.
  - **Clear.** When `op=0, param=1`: `sr_r<=0`, `cnt_r<=0`.
  - **Shift.** When `op=1`: `sr_r<={param, sr_r[width_p-1:1]}` (LSB sent first); `cnt_r` increments, saturating at `width_p`.
    - Extra shifts beyond `width_p` keep shifting; the oldest bits fall out.
  - **Idle.** `op=0, param=0`: no-op.
- Reset FSM driving `pod_reset_o`:
  - ASSERT (`pod_reset_o=1`):
    - `data_r[0]==0` → HOLD, with `hold_cnt_r<=reset_hold_cycles_p-1`.
  - HOLD (`pod_reset_o=1`):
    - `data_r[0]==1` → ASSERT.
    - `hold_cnt_r==0` → RELEASED.
    - Otherwise decrement `hold_cnt_r`.
  - RELEASED (`pod_reset_o=0`):
    - `data_r[0]==1` → ASSERT.
- `hold_cnt_r` width is `BSG_SAFE_CLOG2(reset_hold_cycles_p)`.
- `pod_reset_o` is a direct registered decode of the state (state≠RELEASED), with no combinational path from `tag_i`.

## Timing
- Reset values while `reset_i` is high, applied immediately (async):
  - `sr_r=0`, `cnt_r=0`.
  - `data_r` = bit0 `1`, all other bits `0`.
  - `new_o=0`, `error_o=0`.
  - State ASSERT, so `pod_reset_o=1`.
  - `hold_cnt_r=0`.
- Reset asserted mid-packet or mid-HOLD: all state returns to the reset values; the partial packet is discarded and no `new_o` pulse occurs.
- Commit latency: `en` sampled at edge E → `data_o`/`new_o` valid after E.
- `new_o` deasserts after E+1 unless another changing commit occurs at E+1.
- Release latency: commit with bit0=0 at edge E → HOLD after E+1 → `pod_reset_o` falls after edge E+1+`reset_hold_cycles_p`.
- Assert latency: commit with bit0=1 at E → `pod_reset_o` rises after E+1.
- Back-to-back packets: the first shift may occur in the cycle after `en`; there is no dead cycle.
- Re-asserting during HOLD aborts the release. A subsequent release reloads the full hold count.

## Test plan
- **Basic release.** `width_p=1`, hold=16; after reset, shift `param=0`, then `en` at edge 10 → `data_o=0` and `new_o=1` after edge 10; `pod_reset_o` falls after edge 27.
- **Re-assert.** From RELEASED, shift `1` then `en` at edge E → `pod_reset_o=1` after E+1, `new_o` pulse, `data_o=1`.
- **Short packet.** `width_p=4`; shift 3 bits then `en` → `error_o=1` (sticky), `data_o` unchanged, no `new_o`; a following full 4-bit packet `1,0,1,0` (LSB first) → `data_o=4'b0101`.
- **Identical commit and clear.**
  - Committing a value equal to `data_o` → no `new_o`.
  - Clear (`op=0, param=1`) after 2 shifts, then 4 shifts (`0,1,1,0`) and `en` → `data_o=4'b0110`.
- **Abort in HOLD.** Commit `0`; 5 cycles later commit `1` → `pod_reset_o` never falls. Commit `0` again → fall occurs exactly 17 edges after that commit's `en` edge.
- **Async reset mid-packet.** Pulse `reset_i` between clock edges during a HOLD after 2 shifts → `pod_reset_o=1`, `data_o=1`, `error_o=0` immediately; a fresh full packet afterwards behaves per the basic-release scenario.
